// File: rtl/javk_biu_if.sv
// JAVK bus interface unit signal bundle: core fetch port, core load/store
// port and the external memory bus, with a BIU-side and an environment-side view.
interface javk_biu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) ();
  // Instruction prefetch port
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              if_ready;
  logic              if_flush;
  logic [ADDR_W-1:0] if_flush_addr;
  // Load/store port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // External memory bus
  logic [ADDR_W-1:0] addrbus;
  logic              rw;
  logic [DATA_W-1:0] databus_out;
  logic              databus_oe;
  logic [DATA_W-1:0] databus_in;
  logic              bus_ready;

  modport master (
    output if_valid, if_data,
    input  if_ready, if_flush, if_flush_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    output addrbus, rw, databus_out, databus_oe,
    input  databus_in, bus_ready
  );

  modport slave (
    input  if_valid, if_data,
    output if_ready, if_flush, if_flush_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    input  addrbus, rw, databus_out, databus_oe,
    output databus_in, bus_ready
  );
endinterface

// File: rtl/javk_biu.sv
// JAVK bus interface unit: single-edge bus sequencer with an instruction
// prefetch FIFO, a load/store port that outranks prefetch, and wait states
// driven by bus_ready. One access is in flight at a time.
module javk_biu #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter int                PF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RST_VEC  = '0
) (
  input  logic       clk,
  input  logic       rst,
  javk_biu_if.master bus
);

  localparam int PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int CNT_W = $clog2(PF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(PF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(PF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;
  typedef enum logic [1:0] {ACC_FETCH = 2'd0, ACC_LOAD = 2'd1, ACC_STORE = 2'd2} acc_t;

  state_t            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] queue_q [PF_DEPTH];
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] addrbus_q, addrbus_d;
  logic              rw_q, rw_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              complete_s;
  logic              bus_free_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_after_s;
  logic [ADDR_W-1:0] pc_eff_s;
  logic              data_ok_s;
  logic              sel_data_s;
  logic              sel_fetch_s;

  // Circular pointer advance; PF_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  // A flush squashes any push (discarded fetch) and any pop at the same edge.
  assign complete_s    = (state_q == ST_BUS) && bus.bus_ready;
  assign bus_free_s    = (state_q == ST_IDLE) || bus.bus_ready;
  assign push_s        = complete_s && (acc_q == ACC_FETCH) && !discard_q && !bus.if_flush;
  assign pop_s         = (count_q != '0) && bus.if_ready && !bus.if_flush;
  assign count_after_s = bus.if_flush ? '0 :
                         (push_s && !pop_s) ? count_q + CNT_ONE :
                         (!push_s && pop_s) ? count_q - CNT_ONE : count_q;
  assign pc_eff_s      = bus.if_flush ? bus.if_flush_addr : pc_q;
  // The request being completed (or just acked) is the same request, not a new one.
  assign data_ok_s     = bus.mem_req && !mem_ack_q && !(complete_s && (acc_q != ACC_FETCH));

  // State register: bus sequencer FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arbitrate whenever the bus is free at this edge
  always_comb begin
    sel_data_s  = 1'b0;
    sel_fetch_s = 1'b0;
    state_d     = state_q;
    if (bus_free_s) begin
      sel_data_s  = data_ok_s;
      sel_fetch_s = !data_ok_s && (count_after_s < CNT_DEPTH);
    end else begin
      sel_data_s  = 1'b0;
      sel_fetch_s = 1'b0;
    end
    case (state_q)
      ST_IDLE: state_d = (sel_data_s || sel_fetch_s) ? ST_BUS : ST_IDLE;
      ST_BUS: begin
        if (bus.bus_ready) begin
          state_d = (sel_data_s || sel_fetch_s) ? ST_BUS : ST_IDLE;
        end else begin
          state_d = ST_BUS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath: bus cycle setup, pc, queue pointers, completion
  always_comb begin
    addrbus_d   = addrbus_q;
    rw_d        = rw_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    acc_d       = acc_q;
    pc_d        = pc_eff_s;
    count_d     = count_after_s;
    mem_ack_d   = complete_s && (acc_q != ACC_FETCH);
    mem_rdata_d = mem_rdata_q;
    discard_d   = 1'b0;
    head_d      = head_q;
    tail_d      = tail_q;

    if (sel_data_s) begin
      addrbus_d = bus.mem_addr;
      rw_d      = bus.mem_we;
      oe_d      = bus.mem_we;
      acc_d     = bus.mem_we ? ACC_STORE : ACC_LOAD;
      dout_d    = bus.mem_we ? bus.mem_wdata : dout_q;
    end else if (sel_fetch_s) begin
      addrbus_d = pc_eff_s;
      rw_d      = 1'b0;
      oe_d      = 1'b0;
      acc_d     = ACC_FETCH;
      pc_d      = pc_eff_s + PC_ONE;
    end else if (bus_free_s) begin
      rw_d = 1'b0;
      oe_d = 1'b0;
    end else begin
      rw_d = rw_q;
      oe_d = oe_q;
    end

    if (complete_s && (acc_q == ACC_LOAD)) begin
      mem_rdata_d = bus.databus_in;
    end else begin
      mem_rdata_d = mem_rdata_q;
    end

    // A fetch still waiting on the bus remembers that it was flushed.
    if ((state_q == ST_BUS) && !bus.bus_ready && (acc_q == ACC_FETCH)) begin
      discard_d = discard_q || bus.if_flush;
    end else begin
      discard_d = 1'b0;
    end

    if (bus.if_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = pop_s ? ptr_inc(head_q) : head_q;
      tail_d = push_s ? ptr_inc(tail_q) : tail_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= ACC_FETCH;
      discard_q   <= 1'b0;
      pc_q        <= RST_VEC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= '0;
      addrbus_q   <= '0;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
    end else begin
      acc_q       <= acc_d;
      discard_q   <= discard_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_ack_q   <= mem_ack_d;
      mem_rdata_q <= mem_rdata_d;
      addrbus_q   <= addrbus_d;
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
    end
  end

  // Prefetch queue storage: fetched words written at the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PF_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else if (push_s) begin
      queue_q[tail_q] <= bus.databus_in;
    end
  end

  assign bus.if_valid    = (count_q != '0);
  assign bus.if_data     = queue_q[head_q];
  assign bus.mem_ack     = mem_ack_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.addrbus     = addrbus_q;
  assign bus.rw          = rw_q;
  assign bus.databus_out = dout_q;
  assign bus.databus_oe  = oe_q;

endmodule

// File: tb/tb_javk_biu.sv
// Self-checking bench for javk_biu: directed scenarios followed by random
// traffic, checked against a memory array and an instruction-stream model
// (the core must receive mem[pc], mem[pc+1], ... restarting at each flush target).
module tb_javk_biu;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n_cons   = 0;
  int   base;
  logic rnd_ready = 1'b0;
  logic found;
  logic [15:0] exp_pc;
  logic [7:0]  bus_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];

  javk_biu_if #(.DATA_W(8), .ADDR_W(16)) bus_if ();

  javk_biu #(.DATA_W(8), .ADDR_W(16), .PF_DEPTH(2), .RST_VEC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.databus_in = bus_mem[bus_if.addrbus];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: model the core consuming instructions and the memory taking writes.
  task automatic step();
    logic        pre_wr;
    logic [15:0] pa;
    logic [7:0]  pd;
    if (rnd_ready) bus_if.bus_ready = 1'($urandom_range(0, 1));
    if (!rst && bus_if.if_valid && bus_if.if_ready && !bus_if.if_flush) begin
      chk("ifetch_order", {24'h0, bus_if.if_data}, {24'h0, ref_mem[exp_pc]});
      exp_pc = exp_pc + 16'd1;
      n_cons++;
    end
    if (!rst && bus_if.if_flush) exp_pc = bus_if.if_flush_addr;
    pre_wr = bus_if.bus_ready && bus_if.databus_oe;
    pa     = bus_if.addrbus;
    pd     = bus_if.databus_out;
    @(posedge clk);
    if (pre_wr && !rst) bus_mem[pa] = pd;
    #1;
    chk("oe_only_with_rw", {31'h0, bus_if.databus_oe & ~bus_if.rw}, 32'h0);
  endtask

  task automatic do_mem(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
    logic got;
    got = 1'b0;
    bus_if.mem_req   = 1'b1;
    bus_if.mem_we    = we;
    bus_if.mem_addr  = addr;
    bus_if.mem_wdata = wdata;
    if (we) ref_mem[addr] = wdata;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (bus_if.mem_ack) got = 1'b1;
    end
    chk("mem_ack_seen", {31'h0, got}, 32'h1);
    if (got && !we) chk("load_data", {24'h0, bus_if.mem_rdata}, {24'h0, ref_mem[addr]});
    bus_if.mem_req = 1'b0;
    step();
    chk("ack_single_pulse", {31'h0, bus_if.mem_ack}, 32'h0);
    if (got && we) chk("store_mem", {24'h0, bus_mem[addr]}, {24'h0, wdata});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[16'h0000] = 8'h10; bus_mem[16'h0001] = 8'h11; bus_mem[16'h0002] = 8'h12;
    bus_mem[16'h0003] = 8'h13; bus_mem[16'h1234] = 8'hA5; bus_mem[16'h0200] = 8'h77;
    bus_mem[16'hFFFF] = 8'hEE;
    foreach (ref_mem[i]) ref_mem[i] = bus_mem[i];

    rst = 1'b1;
    bus_if.if_ready = 1'b0; bus_if.if_flush = 1'b0; bus_if.if_flush_addr = 16'h0;
    bus_if.mem_req = 1'b0; bus_if.mem_we = 1'b0; bus_if.mem_addr = 16'h0; bus_if.mem_wdata = 8'h0;
    bus_if.bus_ready = 1'b1;
    exp_pc = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_addrbus", {16'h0, bus_if.addrbus}, 32'h0);
    chk("rst_rw", {31'h0, bus_if.rw}, 32'h0);
    chk("rst_oe", {31'h0, bus_if.databus_oe}, 32'h0);
    chk("rst_dout", {24'h0, bus_if.databus_out}, 32'h0);
    chk("rst_if_valid", {31'h0, bus_if.if_valid}, 32'h0);
    chk("rst_mem_ack", {31'h0, bus_if.mem_ack}, 32'h0);
    chk("rst_mem_rdata", {24'h0, bus_if.mem_rdata}, 32'h0);
    rst = 1'b0;

    // Prefetch fills two entries and stalls
    step(); chk("pf_addr0", {16'h0, bus_if.addrbus}, 32'h0000); chk("pf_rw0", {31'h0, bus_if.rw}, 32'h0);
    step(); chk("pf_addr1", {16'h0, bus_if.addrbus}, 32'h0001);
    chk("pf_valid", {31'h0, bus_if.if_valid}, 32'h1);
    chk("pf_head", {24'h0, bus_if.if_data}, 32'h10);
    step(); step();
    chk("pf_stall_addr", {16'h0, bus_if.addrbus}, 32'h0001);
    chk("pf_stall_head", {24'h0, bus_if.if_data}, 32'h10);
    bus_if.if_ready = 1'b1;
    step(); chk("pf_pc2", {16'h0, bus_if.addrbus}, 32'h0002);
    bus_if.if_ready = 1'b0;
    step();

    // Load with three wait states, queue full so nothing else on the bus
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 16'h1234; bus_if.bus_ready = 1'b0;
    step();
    chk("ld_addr", {16'h0, bus_if.addrbus}, 32'h1234); chk("ld_rw", {31'h0, bus_if.rw}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_addr_hold", {16'h0, bus_if.addrbus}, 32'h1234);
      chk("ld_no_early_ack", {31'h0, bus_if.mem_ack}, 32'h0);
    end
    bus_if.bus_ready = 1'b1;
    step();
    chk("ld_ack", {31'h0, bus_if.mem_ack}, 32'h1);
    chk("ld_rdata", {24'h0, bus_if.mem_rdata}, 32'hA5);
    bus_if.mem_req = 1'b0;
    step();
    chk("ld_ack_pulse", {31'h0, bus_if.mem_ack}, 32'h0);
    chk("ld_no_fetch", {16'h0, bus_if.addrbus}, 32'h1234);

    // Store outranks the fetch freed up by a pop at the same edge
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 16'h8000; bus_if.mem_wdata = 8'h5A;
    ref_mem[16'h8000] = 8'h5A;
    bus_if.if_ready = 1'b1;
    step();
    bus_if.if_ready = 1'b0;
    chk("st_addr", {16'h0, bus_if.addrbus}, 32'h8000);
    chk("st_rw", {31'h0, bus_if.rw}, 32'h1);
    chk("st_oe", {31'h0, bus_if.databus_oe}, 32'h1);
    chk("st_dout", {24'h0, bus_if.databus_out}, 32'h5A);
    step();
    chk("st_ack", {31'h0, bus_if.mem_ack}, 32'h1);
    chk("st_then_fetch", {16'h0, bus_if.addrbus}, 32'h0003);
    chk("st_oe_off", {31'h0, bus_if.databus_oe}, 32'h0);
    chk("st_mem", {24'h0, bus_mem[16'h8000]}, 32'h5A);

    // Flush while fetch of 0x0003 is waiting
    bus_if.mem_req = 1'b0; bus_if.bus_ready = 1'b0;
    step();
    chk("st_ack_pulse", {31'h0, bus_if.mem_ack}, 32'h0);
    bus_if.if_flush = 1'b1; bus_if.if_flush_addr = 16'h0200;
    step();
    bus_if.if_flush = 1'b0;
    chk("fl_valid_low", {31'h0, bus_if.if_valid}, 32'h0);
    bus_if.bus_ready = 1'b1;
    step();
    chk("fl_new_addr", {16'h0, bus_if.addrbus}, 32'h0200);
    chk("fl_drop_stale", {31'h0, bus_if.if_valid}, 32'h0);
    step();
    chk("fl_first_valid", {31'h0, bus_if.if_valid}, 32'h1);
    chk("fl_first_data", {24'h0, bus_if.if_data}, 32'h77);

    // Address wrap at 0xFFFF with continuous consumption
    bus_if.if_flush = 1'b1; bus_if.if_flush_addr = 16'hFFFF; bus_if.if_ready = 1'b1;
    step();
    bus_if.if_flush = 1'b0;
    chk("wrap_addr_ffff", {16'h0, bus_if.addrbus}, 32'hFFFF);
    step();
    chk("wrap_addr_0000", {16'h0, bus_if.addrbus}, 32'h0000);
    base = n_cons;
    repeat (6) step();
    chk("wrap_flow", {31'h0, 1'((n_cons - base) >= 5)}, 32'h1);

    // Random traffic
    rnd_ready = 1'b1;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        do_mem(1'($urandom_range(0, 1)), 16'h8000 + 16'($urandom_range(0, 255)), 8'($urandom));
      end else begin
        bus_if.if_ready      = 1'($urandom_range(0, 1));
        bus_if.if_flush      = (r == 9);
        bus_if.if_flush_addr = 16'($urandom_range(0, 16'h3FFF));
        step();
        bus_if.if_flush = 1'b0;
      end
    end
    rnd_ready = 1'b0;

    // Reset in the middle of a waiting write cycle
    bus_if.if_ready = 1'b0; bus_if.bus_ready = 1'b1;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 16'h8100; bus_if.mem_wdata = 8'h3C;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus_if.addrbus == 16'h8100 && bus_if.databus_oe) found = 1'b1;
    end
    chk("rw_store_issued", {31'h0, found}, 32'h1);
    bus_if.bus_ready = 1'b0;
    step();
    chk("rw_oe_wait", {31'h0, bus_if.databus_oe}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_oe_async", {31'h0, bus_if.databus_oe}, 32'h0);
    chk("rr_rw_async", {31'h0, bus_if.rw}, 32'h0);
    chk("rr_ack_async", {31'h0, bus_if.mem_ack}, 32'h0);
    chk("rr_addr_async", {16'h0, bus_if.addrbus}, 32'h0);
    bus_if.mem_req = 1'b0; bus_if.bus_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_pc = 16'h0000;
    step();
    chk("rr_first_fetch", {16'h0, bus_if.addrbus}, 32'h0000);
    chk("rr_first_rw", {31'h0, bus_if.rw}, 32'h0);
    step();
    chk("rr_second_fetch", {16'h0, bus_if.addrbus}, 32'h0001);
    bus_if.if_ready = 1'b1;
    base = n_cons;
    repeat (8) step();
    chk("rr_stream", {31'h0, 1'((n_cons - base) >= 6)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
